// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: funct3 size codes, size
// encodings, FSM states and small alignment helpers.
package mem_access_unit_pkg;

  localparam int MAU_XLEN = 32;
  localparam int STRB_W   = MAU_XLEN / 8;

  // funct3 access codes as they appear in IR[14:12]
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size as carried in funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mau_state_t;

  // Fetches are always words; funct3[1:0]=11 is treated as a word.
  function automatic logic [1:0] eff_size(input logic iord, input logic [2:0] f3);
    if (!iord || f3[1]) return SZ_WORD;
    else                return f3[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Unified-memory bus between the memory access unit and the memory.
// Handshake: the master raises m_req with m_we/m_addr/m_wdata/m_wstrb stable
// and holds them until the slave returns a single-cycle m_ack; m_rdata is
// valid only in the m_ack cycle. m_ack outside an outstanding request is
// ignored by the master.
interface mem_access_unit_if #(parameter int XLEN = 32);
  logic              m_req;
  logic              m_we;
  logic [XLEN-1:0]   m_addr;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN/8-1:0] m_wstrb;
  logic              m_ack;
  logic [XLEN-1:0]   m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: store strobe generation and data replication,
// alignment check, and load lane extraction with sign/zero extension.
module lsu_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = MAU_XLEN
) (
  input  logic [1:0]        st_size_i,
  input  logic [1:0]        st_addr_lo_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic [XLEN/8-1:0] st_wstrb_o,
  output logic [XLEN-1:0]   st_wdata_o,
  output logic              st_misaligned_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_addr_lo_i,
  input  logic [XLEN-1:0]   ld_rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);
  localparam int SW = XLEN / 8;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: strobes shifted into the addressed lane, data replicated across lanes
  always_comb begin
    st_misaligned_o = is_misaligned(st_size_i, st_addr_lo_i);
    case (st_size_i)
      SZ_BYTE: begin
        st_wstrb_o = SW'(1) << st_addr_lo_i;
        st_wdata_o = {(XLEN/8){st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_wstrb_o = SW'(3) << st_addr_lo_i;
        st_wdata_o = {(XLEN/16){st_data_i[15:0]}};
      end
      default: begin
        st_wstrb_o = '1;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Load side: pick the addressed lane; funct3[2] selects zero-extension
  always_comb begin
    ld_byte = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half = ld_rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
    case (ld_funct3_i[1:0])
      SZ_BYTE: ld_data_o = ld_funct3_i[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                          : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = ld_funct3_i[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                          : {{(XLEN-16){ld_half[15]}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage: converts control-unit strobes into a req/ack bus access,
// owns IR and MDR, stalls the control unit while an access is outstanding.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN           = MAU_XLEN,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   store_data,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   inst_out,
  output logic [XLEN-1:0]   mdr_out,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err,
  output mau_state_t        state_o,
  mem_access_unit_if.master mem
);
  localparam int SW = XLEN / 8;

  mau_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       access, accept, reject, done, timeout;

  logic [XLEN-1:0] req_addr;
  logic [1:0]      st_size;
  logic [SW-1:0]   al_wstrb;
  logic [XLEN-1:0] al_wdata, al_ld_data;
  logic            al_mis;

  // Attributes of the outstanding access, captured in the accept cycle
  logic [1:0]      addr_lo_q;
  logic [2:0]      ld_f3_q;
  logic            irwrite_q, iord_q;

  logic            m_req_q, m_we_q;
  logic [XLEN-1:0] m_addr_q, m_wdata_q;
  logic [SW-1:0]   m_wstrb_q;
  logic            misaligned_q, bus_err_q;
  logic [XLEN-1:0] inst_q, mdr_q;

  assign access   = mem_read | mem_write;
  assign req_addr = IorD ? alu_out : pc;
  assign st_size  = eff_size(IorD, funct3);

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size_i       (st_size),
    .st_addr_lo_i    (req_addr[1:0]),
    .st_data_i       (store_data),
    .st_wstrb_o      (al_wstrb),
    .st_wdata_o      (al_wdata),
    .st_misaligned_o (al_mis),
    .ld_funct3_i     (ld_f3_q),
    .ld_addr_lo_i    (addr_lo_q),
    .ld_rdata_i      (mem.m_rdata),
    .ld_data_o       (al_ld_data)
  );

  // Next state, timeout counter and stall; stall drops in the ack/timeout cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access) begin
          if (al_mis) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem.m_ack) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, bus output registers, error pulses and IR/MDR capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      ld_f3_q      <= '0;
      irwrite_q    <= 1'b0;
      iord_q       <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      inst_q       <= '0;
      mdr_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= reject;
      bus_err_q    <= timeout;
      if (accept) begin
        m_req_q   <= 1'b1;
        m_we_q    <= mem_write;
        m_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
        m_wdata_q <= al_wdata;
        m_wstrb_q <= mem_write ? al_wstrb : '0;
        addr_lo_q <= req_addr[1:0];
        ld_f3_q   <= IorD ? funct3 : F3_LW;
        irwrite_q <= IRWrite;
        iord_q    <= IorD;
      end else if (done || timeout) begin
        m_req_q   <= 1'b0;
        m_we_q    <= 1'b0;
        m_wstrb_q <= '0;
      end
      if (done && !m_we_q) begin
        if (irwrite_q) inst_q <= mem.m_rdata;
        if (iord_q)    mdr_q  <= al_ld_data;
      end
    end
  end

  assign mem.m_req   = m_req_q;
  assign mem.m_we    = m_we_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_wdata = m_wdata_q;
  assign mem.m_wstrb = m_wstrb_q;
  assign inst_out    = inst_q;
  assign mdr_out     = mdr_q;
  assign misaligned  = misaligned_q;
  assign bus_err     = bus_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written timeout and
// reset sequences, then random accesses against a behavioural model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, IorD, IRWrite;
  logic [31:0] pc, alu_out, store_data;
  logic [2:0]  funct3;
  logic [31:0] inst_out, mdr_out;
  logic        stall, misaligned, bus_err;
  mau_state_t  state_o;

  mem_access_unit_if #(.XLEN(32)) mem ();

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .IorD(IorD), .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out),
    .store_data(store_data), .funct3(funct3), .inst_out(inst_out),
    .mdr_out(mdr_out), .stall(stall), .misaligned(misaligned),
    .bus_err(bus_err), .state_o(state_o), .mem(mem)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- types, scoreboard ----------------
  typedef struct {
    logic rd, wr, iord, irw;
    logic [31:0] pc, alu, sd;
    logic [2:0] f3;
    logic [31:0] rdata;
    int ack_wait;
  } stim_t;

  typedef struct {
    logic mis, we;
    logic [31:0] addr, wdata;
    logic [3:0] wstrb;
    logic [31:0] inst, mdr;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cur_inst, cur_mdr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic stim_t mk_s(input logic rd, wr, iord, irw, input logic [31:0] p, a, sd,
                                 input logic [2:0] f3, input logic [31:0] rdata, input int aw);
    stim_t s;
    s.rd = rd; s.wr = wr; s.iord = iord; s.irw = irw; s.pc = p; s.alu = a; s.sd = sd;
    s.f3 = f3; s.rdata = rdata; s.ack_wait = aw;
    return s;
  endfunction

  function automatic exp_t mk_e(input logic mis, we, input logic [31:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, inst, mdr);
    exp_t e;
    e.mis = mis; e.we = we; e.addr = addr; e.wstrb = wstrb; e.wdata = wdata;
    e.inst = inst; e.mdr = mdr;
    return e;
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s; v.e = e;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Works in bytes and powers of two rather than lanes and muxes.
  function automatic exp_t model(input stim_t s, input logic [31:0] inst0, input logic [31:0] mdr0);
    exp_t e;
    logic [31:0] addr;
    int nb, a;
    longint unsigned span, lane, sdv, rdv;
    addr = s.iord ? s.alu : s.pc;
    if (!s.iord || s.f3[1]) nb = 4;
    else if (s.f3[0])       nb = 2;
    else                    nb = 1;
    a    = int'(addr % 4);
    span = 64'd1 << (8 * nb);
    sdv  = 64'(s.sd);
    rdv  = 64'(s.rdata);
    e.mis   = (a % nb) != 0;
    e.addr  = addr - 32'(a);
    e.we    = s.wr;
    e.wstrb = s.wr ? 4'(((1 << nb) - 1) << a) : 4'b0000;
    e.wdata = '0;
    if (s.wr)
      for (int k = 0; k < 4; k += nb) e.wdata = e.wdata | 32'((sdv % span) << (8 * k));
    e.inst = inst0;
    e.mdr  = mdr0;
    if (!e.mis && s.rd && !s.wr) begin
      if (s.irw) e.inst = s.rdata;
      if (s.iord) begin
        lane = (rdv >> (8 * a)) % span;
        if (nb < 4 && !s.f3[2] && lane >= span / 2) e.mdr = 32'(lane + (64'h1_0000_0000 - span));
        else                                        e.mdr = 32'(lane);
      end
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Entered and left just after a rising edge, with the DUT in IDLE.
  task automatic do_access(input stim_t s, input exp_t e, input string tag);
    int  stall_cnt;
    int  w;
    bit  done;
    logic [31:0] got;
    exp_q.push_back(e.inst);
    exp_q.push_back(e.mdr);
    mem_read = s.rd; mem_write = s.wr; IorD = s.iord; IRWrite = s.irw;
    pc = s.pc; alu_out = s.alu; store_data = s.sd; funct3 = s.f3;
    mem.m_ack = 1'b0;
    @(negedge clk);
    stall_cnt = int'(stall);
    @(posedge clk); #1;
    // Inputs are only sampled in the accept cycle; scramble them afterwards.
    mem_read = 1'b0; mem_write = 1'b0; IorD = 1'($urandom); IRWrite = 1'($urandom);
    pc = $urandom; alu_out = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (e.mis) begin
      check({tag, "_req_stall"}, 32'(stall_cnt), 0);
      @(negedge clk);
      check({tag, "_mis_pulse"}, 32'(misaligned), 1);
      check({tag, "_mis_noreq"}, 32'(mem.m_req), 0);
      check({tag, "_mis_stall"}, 32'(stall), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_mis_clear"}, 32'(misaligned), 0);
    end else begin
      w = 0;
      done = 0;
      while (!done && w < 10) begin
        mem.m_ack   = (w == s.ack_wait);
        mem.m_rdata = (w == s.ack_wait) ? s.rdata : $urandom;
        @(negedge clk);
        if (w == 0) begin
          check({tag, "_m_req"},   32'(mem.m_req), 1);
          check({tag, "_m_addr"},  mem.m_addr, e.addr);
          check({tag, "_m_we"},    32'(mem.m_we), 32'(e.we));
          check({tag, "_m_wstrb"}, 32'(mem.m_wstrb), 32'(e.wstrb));
          check({tag, "_no_mis"},  32'(misaligned), 0);
          if (e.we) check({tag, "_m_wdata"}, mem.m_wdata, e.wdata);
        end
        if (mem.m_ack) begin
          check({tag, "_ack_stall"}, 32'(stall), 0);
          done = 1;
        end else begin
          stall_cnt += int'(stall);
        end
        w++;
        @(posedge clk); #1;
      end
      mem.m_ack = 1'b0;
      total++;
      if (!done) begin
        bad++;
        $display("FAIL %s_ack_bound: ack never delivered within bound", tag);
      end
      check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(s.ack_wait + 1));
      @(negedge clk);
      check({tag, "_req_drop"}, 32'(mem.m_req), 0);
    end
    got = exp_q.pop_front();
    check({tag, "_inst"}, inst_out, got);
    got = exp_q.pop_front();
    check({tag, "_mdr"}, mdr_out, got);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    exp_t  e;
    reset = 1'b1;
    mem_read = 0; mem_write = 0; IorD = 0; IRWrite = 0;
    pc = 0; alu_out = 0; store_data = 0; funct3 = 0;
    mem.m_ack = 1'b0; mem.m_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inst",   inst_out, 0);
    check("rst_mdr",    mdr_out, 0);
    check("rst_m_req",  32'(mem.m_req), 0);
    check("rst_m_we",   32'(mem.m_we), 0);
    check("rst_m_addr", mem.m_addr, 0);
    check("rst_m_wdata", mem.m_wdata, 0);
    check("rst_m_wstrb", 32'(mem.m_wstrb), 0);
    check("rst_stall",  32'(stall), 0);
    check("rst_mis",    32'(misaligned), 0);
    check("rst_berr",   32'(bus_err), 0);
    check("rst_state",  32'(state_o), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors: {stimulus, expected bus fields and IR/MDR afterwards}
    add(mk_s(1,0,0,1, 32'h10,  32'h103, 0,            3'b000, 32'h00500093, 3),
        mk_e(0,0, 32'h10,  4'b0000, 0,            32'h00500093, 32'h0));
    add(mk_s(1,0,1,0, 32'h44,  32'h103, 0,            3'b000, 32'h80FFFFFF, 0),
        mk_e(0,0, 32'h100, 4'b0000, 0,            32'h00500093, 32'hFFFFFF80));
    add(mk_s(1,0,1,0, 32'h44,  32'h103, 0,            3'b100, 32'h80FFFFFF, 1),
        mk_e(0,0, 32'h100, 4'b0000, 0,            32'h00500093, 32'h00000080));
    add(mk_s(1,0,1,0, 32'h44,  32'h102, 0,            3'b001, 32'h80FFFFFF, 2),
        mk_e(0,0, 32'h100, 4'b0000, 0,            32'h00500093, 32'hFFFF80FF));
    add(mk_s(0,1,1,0, 32'h0,   32'h202, 32'h1234ABCD, 3'b001, 32'hDEADBEEF, 1),
        mk_e(0,1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00500093, 32'hFFFF80FF));
    add(mk_s(1,0,1,0, 32'h0,   32'h101, 0,            3'b010, 32'h0,        0),
        mk_e(1,0, 32'h0,   4'b0000, 0,            32'h00500093, 32'hFFFF80FF));
    add(mk_s(1,0,0,1, 32'h6,   32'h8,   0,            3'b010, 32'h0,        0),
        mk_e(1,0, 32'h0,   4'b0000, 0,            32'h00500093, 32'hFFFF80FF));
    add(mk_s(1,1,1,1, 32'h0,   32'h300, 32'hCAFEF00D, 3'b010, 32'h11111111, 0),
        mk_e(0,1, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h00500093, 32'hFFFF80FF));
    add(mk_s(1,0,1,0, 32'h0,   32'h106, 0,            3'b101, 32'h80017FFF, 0),
        mk_e(0,0, 32'h104, 4'b0000, 0,            32'h00500093, 32'h00008001));
    add(mk_s(0,1,1,0, 32'h0,   32'h401, 32'h000000A5, 3'b000, 32'h0,        2),
        mk_e(0,1, 32'h400, 4'b0010, 32'hA5A5A5A5, 32'h00500093, 32'h00008001));
    add(mk_s(1,0,1,0, 32'h0,   32'h404, 0,            3'b010, 32'h89ABCDEF, 3),
        mk_e(0,0, 32'h404, 4'b0000, 0,            32'h00500093, 32'h89ABCDEF));
    add(mk_s(1,0,1,0, 32'h0,   32'h408, 0,            3'b011, 32'h13572468, 2),
        mk_e(0,0, 32'h408, 4'b0000, 0,            32'h00500093, 32'h13572468));
    add(mk_s(1,0,1,0, 32'h0,   32'h103, 0,            3'b001, 32'h0,        0),
        mk_e(1,0, 32'h0,   4'b0000, 0,            32'h00500093, 32'h13572468));
    add(mk_s(1,0,0,0, 32'h20,  32'h0,   0,            3'b000, 32'hFFFFFFFF, 1),
        mk_e(0,0, 32'h20,  4'b0000, 0,            32'h00500093, 32'h13572468));

    for (int i = 0; i < vecs.size(); i++) begin
      do_access(vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));
    end
    cur_inst = 32'h00500093;
    cur_mdr  = 32'h13572468;

    // Timeout: no ack for TO WAIT cycles, then a late ack in IDLE
    mem_read = 1; IorD = 0; IRWrite = 1; pc = 32'h80; mem.m_ack = 0;
    @(negedge clk);
    check("to_req_stall", 32'(stall), 1);
    @(posedge clk); #1;
    mem_read = 0;
    for (int w = 0; w < TO; w++) begin
      @(negedge clk);
      check($sformatf("to_wait%0d_req", w), 32'(mem.m_req), 1);
      check($sformatf("to_wait%0d_berr", w), 32'(bus_err), 0);
      if (w < TO - 1) check($sformatf("to_wait%0d_stall", w), 32'(stall), 1);
      @(posedge clk); #1;
    end
    mem.m_ack = 1; mem.m_rdata = 32'hFFFF0000;
    @(negedge clk);
    check("to_berr_pulse", 32'(bus_err), 1);
    check("to_req_drop",   32'(mem.m_req), 0);
    check("to_stall",      32'(stall), 0);
    check("to_state",      32'(state_o), 32'(ST_IDLE));
    @(posedge clk); #1;
    mem.m_ack = 0;
    @(negedge clk);
    check("to_berr_clear", 32'(bus_err), 0);
    check("to_late_inst",  inst_out, cur_inst);
    check("to_late_req",   32'(mem.m_req), 0);
    @(posedge clk); #1;

    // Reset while WAIT is outstanding, then a late ack
    mem_read = 1; IorD = 0; IRWrite = 1; pc = 32'hC0;
    @(posedge clk); #1;
    mem_read = 0;
    @(negedge clk);
    check("rw_in_wait", 32'(mem.m_req), 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; mem.m_ack = 1; mem.m_rdata = 32'h0BADC0DE;
    @(negedge clk);
    check("rw_req",   32'(mem.m_req), 0);
    check("rw_stall", 32'(stall), 0);
    check("rw_inst",  inst_out, 0);
    check("rw_mdr",   mdr_out, 0);
    check("rw_state", 32'(state_o), 32'(ST_IDLE));
    @(posedge clk); #1;
    mem.m_ack = 0;
    @(negedge clk);
    check("rw_late_inst", inst_out, 0);
    @(posedge clk); #1;
    cur_inst = 0;
    cur_mdr  = 0;

    // Random accesses against the model
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      s.rd  = (kind != 1);
      s.wr  = (kind == 1) || (kind == 2);
      s.iord = ($urandom_range(0, 3) != 0);
      s.irw  = 1'($urandom);
      s.pc   = $urandom;
      s.alu  = $urandom;
      if ($urandom_range(0, 1) != 0) begin
        s.pc[1:0]  = 2'b00;
        s.alu[1:0] = 2'b00;
      end
      s.sd = $urandom;
      s.f3 = 3'($urandom_range(0, 7));
      s.rdata = $urandom;
      s.ack_wait = $urandom_range(0, TO - 1);
      e = model(s, cur_inst, cur_mdr);
      do_access(s, e, $sformatf("rnd%0d", i));
      cur_inst = e.inst;
      cur_mdr  = e.mdr;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
